cr_kme_fifo_arb: RTL
====================

// Module: cr_kme_fifo_arb
// PURPOSE
//  Round-robin, packet-aware arbiter that shares one KME staging FIFO among N_REQ producers.
//  Sits directly in front of the FIFO input:
//   - forwards the winning producer's beat onto the FIFO's wdata/valid;
//   - honours the FIFO stall so the FIFO can never overflow;
//   - holds the grant until end-of-packet;
//   - keeps sticky FIFO over/underflow diagnostics.
// PARAMETERS
//  N_REQ        4   number of producers; any value >= 2, power of 2 not required
//  DATA_SIZE    96  beat width; equals the FIFO's DATA_SIZE
//  LOCK_ON_EOP  1   1: grant held from first beat to eop beat; 0: re-arbitrate after every beat
// PORTS
//  clk             in   1                clock
//  rst_n           in   1                reset, asynchronous, active-low
//  req_valid       in   N_REQ            producer i has a beat
//  req_data        in   N_REQ*DATA_SIZE  beat of producer i in bits [i*DATA_SIZE +: DATA_SIZE]
//  req_eop         in   N_REQ            beat of producer i is the last of its packet
//  req_stall       out  N_REQ            1 = producer i must hold its beat
//  fifo_in         out  DATA_SIZE        to FIFO wdata
//  fifo_in_valid   out  1                to FIFO write enable
//  fifo_in_stall   in   1                from FIFO; 1 = no free slot or override
//  fifo_overflow   in   1                from FIFO, pulse
//  fifo_underflow  in   1                from FIFO, pulse
//  arb_hold        in   1                1 = start no new packet
//  grant           out  N_REQ            one-hot current grant (all zero if none)
//  locked          out  1                registered; 1 = mid-packet, grant pinned to owner
//  err_overflow    out  1                sticky
//  err_underflow   out  1                sticky
//  err_clr         in   1                clears both sticky errors
// BEHAVIOUR
//  Accept and forwarding
//   - Beat i accepted in a cycle iff req_valid[i] & !req_stall[i].
//   - Accepted beat goes to the FIFO in the same cycle (zero latency, no data register).
//     fifo_in = req_data[winner], fifo_in_valid = 1.
//   - With no accept: fifo_in_valid = 0 and fifo_in = 0.
//   - req_stall[i] = fifo_in_stall | !grant[i]. So fifo_in_valid is never 1 while fifo_in_stall = 1.
//   - Producers hold valid/data/eop stable until accepted; the arbiter never drops a held beat.
//  State machine (2 states)
//   - IDLE:
//     - grant = first req_valid bit at or after rr_ptr, searching with wrap; zero if arb_hold.
//     - grant is recomputed every cycle; nothing is committed until a beat is accepted.
//     - Accepted beat with !eop and LOCK_ON_EOP=1 -> LOCKED, owner <= winner.
//     - Accepted eop beat, or any beat with LOCK_ON_EOP=0 -> stay IDLE, rr_ptr <= (winner+1) mod N_REQ.
//   - LOCKED:
//     - grant = onehot(owner), even if req_valid[owner] = 0 (bubble); arb_hold is ignored.
//     - Accepted eop beat from owner -> IDLE, rr_ptr <= (owner+1) mod N_REQ.
//   - locked = (state == LOCKED).
//  Invariants
//   - rr_ptr never moves on stall or when no beat is accepted.
//   - Wrap at N_REQ-1 -> 0.
//   - rr_ptr width is max(1, $clog2(N_REQ)).
//  Sticky errors
//   - err_* <= 1 on the respective FIFO pulse; err_clr clears; set wins over a same-cycle clear.
//   - Overflow is diagnostic only: by construction the arbiter itself never causes it.
//  Reset (async assert, sync release)
//   - state IDLE, rr_ptr 0, owner 0, locked 0, err_* 0.
//   - Combinational outputs with all req_valid = 0: grant 0, req_stall all 1, fifo_in_valid 0, fifo_in 0.
//   - Reset mid-packet drops the lock; packet recovery is the producer's job.
// STRUCTURE
//  Package cr_kme_fifo_arb_pkg:
//   - arb_state_e {ARB_IDLE, ARB_LOCKED};
//   - localparam-style function for rr_ptr width;
//   - default DATA_SIZE constant shared with the FIFO instance.
//  Sub-module cr_kme_rr_pick (combinational):
//   - inputs req[N], ptr; outputs one-hot gnt and binary idx;
//   - double-width rotate-and-priority.
//  Top holds the FSM, owner/ptr registers, data mux and sticky errors.
// TESTING
//  1 N_REQ=4, all valid, single-beat eop packets, stall 0 -> grants 0,1,2,3,0 on consecutive cycles;
//    fifo_in_valid=1 every cycle.
//  2 Req1 sends 3-beat packet while req0/req2 valid -> grant stays 4'b0010 for 3 accepts, locked=1 for 2 cycles;
//    next grant 4'b0100.
//  3 fifo_in_stall=1 for 5 cycles mid-packet -> fifo_in_valid=0, req_stall=4'b1111, rr_ptr/owner unchanged;
//    resume on same beat.
//  4 arb_hold=1 in IDLE with req=4'b1111 -> grant=0; arb_hold=1 while LOCKED -> packet completes, then grant=0.
//  5 Pulse fifo_overflow with err_clr=1 same cycle -> err_overflow=1;
//    next cycle err_clr=1 alone -> 0; reset mid-packet -> locked=0, rr_ptr=0.

Source files
------------

// File: rtl/cr_kme_fifo_arb_pkg.sv
// Shared types and constants for the KME staging-FIFO arbiter.
package cr_kme_fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Beat width shared with the KME staging FIFO instance.
  localparam int unsigned KME_DATA_SIZE = 96;

  // Round-robin pointer width: max(1, clog2(n)).
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cr_kme_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, with wrap.
module cr_kme_rr_pick
  import cr_kme_fifo_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic [N-1:0] rot;
  logic         found;
  int unsigned  sum;

  // Rotate the doubled request vector down by ptr, then take the lowest set bit.
  always_comb begin
    rot   = N'({req, req} >> ptr);
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    sum   = 0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!found && rot[j]) begin
        found = 1'b1;
        sum   = int'(ptr) + j;
        if (sum >= N) sum = sum - N;
        idx   = PW'(sum);
        gnt   = N'(1) << sum;
      end
    end
  end

endmodule

// File: rtl/cr_kme_fifo_arb.sv
// Packet-aware round-robin arbiter feeding one KME staging FIFO.
module cr_kme_fifo_arb
  import cr_kme_fifo_arb_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_SIZE   = KME_DATA_SIZE,
  parameter bit          LOCK_ON_EOP = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*DATA_SIZE-1:0] req_data,
  input  logic [N_REQ-1:0]           req_eop,
  output logic [N_REQ-1:0]           req_stall,
  output logic [DATA_SIZE-1:0]       fifo_in,
  output logic                       fifo_in_valid,
  input  logic                       fifo_in_stall,
  input  logic                       fifo_overflow,
  input  logic                       fifo_underflow,
  input  logic                       arb_hold,
  output logic [N_REQ-1:0]           grant,
  output logic                       locked,
  output logic                       err_overflow,
  output logic                       err_underflow,
  input  logic                       err_clr
);

  localparam int unsigned PW = ptr_width(N_REQ);

  arb_state_e    state, state_nx;
  logic [PW-1:0] rr_ptr, ptr_nx;
  logic [PW-1:0] owner, owner_nx;
  logic [N_REQ-1:0] pick_gnt;
  logic [PW-1:0] pick_idx;
  logic [PW-1:0] win;
  logic [PW-1:0] win_next;
  logic          accept;
  logic          win_eop;

  cr_kme_rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  // Grant selection, stall fan-out and zero-latency data forwarding.
  always_comb begin
    grant = '0;
    win   = '0;
    if (state == ARB_LOCKED) begin
      grant[owner] = 1'b1;
      win          = owner;
    end else if (!arb_hold) begin
      grant = pick_gnt;
      win   = pick_idx;
    end
    req_stall     = {N_REQ{fifo_in_stall}} | ~grant;
    accept        = |(req_valid & ~req_stall);
    win_eop       = req_eop[win];
    win_next      = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);
    fifo_in_valid = accept;
    fifo_in       = accept ? req_data[win*DATA_SIZE +: DATA_SIZE] : '0;
  end

  // Next-state: commit only on an accepted beat; pointer advances past the winner at packet end.
  always_comb begin
    state_nx = state;
    ptr_nx   = rr_ptr;
    owner_nx = owner;
    if (accept) begin
      unique case (state)
        ARB_IDLE: begin
          if (LOCK_ON_EOP && !win_eop) begin
            state_nx = ARB_LOCKED;
            owner_nx = win;
          end else begin
            ptr_nx = win_next;
          end
        end
        ARB_LOCKED: begin
          if (win_eop) begin
            state_nx = ARB_IDLE;
            ptr_nx   = win_next;
          end
        end
        default: state_nx = ARB_IDLE;
      endcase
    end
  end

  // State, pointer and owner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ARB_IDLE;
      rr_ptr <= '0;
      owner  <= '0;
    end else begin
      state  <= state_nx;
      rr_ptr <= ptr_nx;
      owner  <= owner_nx;
    end
  end

  // Sticky FIFO diagnostics; a new pulse wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (fifo_overflow)       err_overflow <= 1'b1;
      else if (err_clr)        err_overflow <= 1'b0;
      if (fifo_underflow)      err_underflow <= 1'b1;
      else if (err_clr)        err_underflow <= 1'b0;
    end
  end

  assign locked = (state == ARB_LOCKED);

endmodule
